// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer.
package trace_pkg;

    localparam int DROP_W   = 16;
    localparam int XLEN_D   = 32;
    localparam int ADDR_W_D = 32;
    localparam int NCH_D    = 2;
    localparam int TS_W_D   = 32;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W_D = ch_w(NCH_D);

    typedef struct packed {
        logic [CH_W_D-1:0]   ch;
        logic [ADDR_W_D-1:0] addr;
        logic [XLEN_D-1:0]   data;
        logic [TS_W_D-1:0]   ts;
    } trace_entry_t;

endpackage

// File: rtl/trace_enq_compact.sv
// Prefix-sum compaction: packs the valid channels into consecutive slot offsets,
// lowest channel first, and admits only as many as there is space for.
module trace_enq_compact #(
    parameter int NCH   = 2,
    parameter int CNT_W = 5,
    parameter int OFF_W = 4
) (
    input  logic [NCH-1:0]            valid,
    input  logic [CNT_W-1:0]          space,
    output logic [NCH-1:0]            wr_en,
    output logic [NCH-1:0][OFF_W-1:0] wr_off,
    output logic [CNT_W-1:0]          n_valid,
    output logic [CNT_W-1:0]          n_acc
);

    logic [CNT_W-1:0] run;

    always_comb begin
        run    = '0;
        wr_en  = '0;
        wr_off = '0;
        for (int k = 0; k < NCH; k++) begin
            if (valid[k]) begin
                wr_off[k] = run[OFF_W-1:0];
                wr_en[k]  = (run < space);
                run       = run + CNT_W'(1);
            end
        end
        n_valid = run;
        n_acc   = (run < space) ? run : space;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Multi-channel timestamped commit-event FIFO with first-word-fall-through drain
// and saturating loss accounting.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int NCH    = 2,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    localparam int CH_W  = ch_w(NCH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [NCH-1:0]        i_ch_valid,
    input  logic [NCH*ADDR_W-1:0] i_ch_addr,
    input  logic [NCH*XLEN-1:0]   i_ch_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CH_W-1:0]       o_ch,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [XLEN-1:0]       o_data,
    output logic [TS_W-1:0]       o_ts,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full,
    output logic [DROP_W-1:0]     o_drop_cnt,
    input  logic                  i_clr_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CH_W-1:0]   mem_ch   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [XLEN-1:0]   mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [TS_W-1:0]  ts;
    logic             pop;
    logic [CNT_W-1:0] space, count_next, n_valid, n_acc, n_drop;
    logic [NCH-1:0]   v_masked, wr_en;
    logic [NCH-1:0][PTR_W-1:0] wr_off, wr_idx;
    logic [DROP_W:0]  drop_sum;

    logic [CH_W-1:0]   head_ch;
    logic [ADDR_W-1:0] head_addr;
    logic [XLEN-1:0]   head_data;
    logic [TS_W-1:0]   head_ts;

    assign v_masked    = i_ch_valid & {NCH{i_en}};
    assign pop         = o_valid & i_ready;
    assign space       = CNT_W'(DEPTH) - o_count + CNT_W'(pop);
    assign count_next  = o_count + n_acc - CNT_W'(pop);
    assign rd_ptr_next = rd_ptr + PTR_W'(pop);
    assign n_drop      = n_valid - n_acc;
    assign drop_sum    = {1'b0, (i_clr_drop ? {DROP_W{1'b0}} : o_drop_cnt)} + (DROP_W+1)'(n_drop);

    trace_enq_compact #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .OFF_W (PTR_W)
    ) u_enq (
        .valid   (v_masked),
        .space   (space),
        .wr_en   (wr_en),
        .wr_off  (wr_off),
        .n_valid (n_valid),
        .n_acc   (n_acc)
    );

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            wr_idx[k] = wr_ptr + wr_off[k];
        end
    end

    // The next head may be a slot written this very cycle, so bypass it from the inputs.
    always_comb begin
        head_ch   = mem_ch[rd_ptr_next];
        head_addr = mem_addr[rd_ptr_next];
        head_data = mem_data[rd_ptr_next];
        head_ts   = mem_ts[rd_ptr_next];
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k] && (wr_idx[k] == rd_ptr_next)) begin
                head_ch   = CH_W'(k);
                head_addr = i_ch_addr[k*ADDR_W +: ADDR_W];
                head_data = i_ch_data[k*XLEN +: XLEN];
                head_ts   = ts;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k]) begin
                mem_ch[wr_idx[k]]   <= CH_W'(k);
                mem_addr[wr_idx[k]] <= i_ch_addr[k*ADDR_W +: ADDR_W];
                mem_data[wr_idx[k]] <= i_ch_data[k*XLEN +: XLEN];
                mem_ts[wr_idx[k]]   <= ts;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ts         <= '0;
            o_count    <= '0;
            o_full     <= 1'b0;
            o_valid    <= 1'b0;
            o_drop_cnt <= '0;
            o_ch       <= '0;
            o_addr     <= '0;
            o_data     <= '0;
            o_ts       <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(n_acc);
            rd_ptr     <= rd_ptr_next;
            ts         <= ts + TS_W'(1);
            o_count    <= count_next;
            o_full     <= (count_next == CNT_W'(DEPTH));
            o_valid    <= (count_next != '0);
            o_drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            if (count_next != '0) begin
                o_ch   <= head_ch;
                o_addr <= head_addr;
                o_data <= head_data;
                o_ts   <= head_ts;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised and directed bench for commit_trace_buffer against a queue-based model.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              i_rst, i_en, i_ready, i_clr_drop;
    logic [NCH-1:0]    i_ch_valid;
    logic [NCH*32-1:0] i_ch_addr, i_ch_data;
    logic              o_valid, o_full;
    logic [0:0]        o_ch;
    logic [31:0]       o_addr, o_data, o_ts;
    logic [4:0]        o_count;
    logic [15:0]       o_drop_cnt;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .XLEN(32), .ADDR_W(32), .NCH(NCH), .DEPTH(DEPTH), .TS_W(32)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_ch_valid(i_ch_valid),
        .i_ch_addr(i_ch_addr), .i_ch_data(i_ch_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_ch(o_ch), .o_addr(o_addr), .o_data(o_data),
        .o_ts(o_ts), .o_count(o_count), .o_full(o_full),
        .o_drop_cnt(o_drop_cnt), .i_clr_drop(i_clr_drop)
    );

    trace_entry_t q[$];
    trace_entry_t last_head;
    logic [31:0]  ts_m;
    int           drop_m;
    int           vectors = 0;
    int           miscompares = 0;

    // Applies one cycle of stimulus and advances the reference model across the edge.
    task automatic step(input logic rst, input logic en, input logic [NCH-1:0] v,
                        input logic [NCH*32-1:0] a, input logic [NCH*32-1:0] d,
                        input logic rdy, input logic clr);
        trace_entry_t e;
        trace_entry_t incoming[$];
        int space, acc, drp;
        bit pop;
        i_rst = rst; i_en = en; i_ch_valid = v; i_ch_addr = a; i_ch_data = d;
        i_ready = rdy; i_clr_drop = clr;
        if (rst) begin
            q.delete();
            ts_m = 0; drop_m = 0; last_head = '0;
        end else begin
            acc = 0; drp = 0;
            pop = rdy && (q.size() > 0);
            space = DEPTH - q.size() + int'(pop);
            for (int k = 0; k < NCH; k++) begin
                if (en && v[k]) begin
                    if (acc < space) begin
                        e.ch = 1'(k); e.addr = a[k*32 +: 32]; e.data = d[k*32 +: 32]; e.ts = ts_m;
                        incoming.push_back(e);
                        acc++;
                    end else drp++;
                end
            end
            if (pop) void'(q.pop_front());
            foreach (incoming[i]) q.push_back(incoming[i]);
            drop_m = (clr ? 0 : drop_m) + drp;
            if (drop_m > 65535) drop_m = 65535;
            ts_m = ts_m + 1;
            if (q.size() > 0) last_head = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (o_valid !== 1'b0 || o_count !== 5'd0 || o_full !== 1'b0 || o_drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_status: got v=%b cnt=%0d full=%b drop=%0d, want 0 0 0 0", o_valid, o_count, o_full, o_drop_cnt);
        end
        vectors++;
        if (o_ch !== 1'b0 || o_addr !== 32'd0 || o_data !== 32'd0 || o_ts !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_head: got ch=%0d addr=%h data=%h ts=%0d, want all 0", o_ch, o_addr, o_data, o_ts);
        end
    endtask

    task automatic test_single;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);
        step(1'b0, 1'b1, 2'b01, {32'd0, 32'd5}, {32'd0, 32'hDEAD_BEEF}, 1'b1, 1'b0);
        vectors++;
        if (o_valid !== 1'b1 || o_ch !== 1'b0 || o_addr !== 32'd5 || o_data !== 32'hDEAD_BEEF || o_ts !== 32'd3) begin
            miscompares++;
            $display("FAIL single_head: got v=%b ch=%0d addr=%0d data=%h ts=%0d, want 1 0 5 deadbeef 3", o_valid, o_ch, o_addr, o_data, o_ts);
        end
        idle(1'b1);
        vectors++;
        if (o_valid !== 1'b0 || o_count !== 5'd0 || o_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL single_pop: got v=%b cnt=%0d data=%h, want 0 0 deadbeef(held)", o_valid, o_count, o_data);
        end
    endtask

    task automatic test_multi_enqueue;
        logic [31:0] exp_ts;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        idle(1'b0);
        exp_ts = ts_m;
        step(1'b0, 1'b1, 2'b11, {32'd2, 32'd1}, {32'hB, 32'hA}, 1'b0, 1'b0);
        vectors++;
        if (o_count !== 5'd2 || o_ch !== 1'b0 || o_addr !== 32'd1 || o_ts !== exp_ts) begin
            miscompares++;
            $display("FAIL multi_first: got cnt=%0d ch=%0d addr=%0d ts=%0d, want 2 0 1 %0d", o_count, o_ch, o_addr, o_ts, exp_ts);
        end
        idle(1'b1);
        vectors++;
        if (o_valid !== 1'b1 || o_ch !== 1'b1 || o_addr !== 32'd2 || o_data !== 32'hB || o_ts !== exp_ts) begin
            miscompares++;
            $display("FAIL multi_second: got v=%b ch=%0d addr=%0d data=%h ts=%0d, want 1 1 2 b %0d", o_valid, o_ch, o_addr, o_data, o_ts, exp_ts);
        end
        idle(1'b1);
    endtask

    task automatic test_overflow;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b1, 2'b01, {32'd0, 32'(100 + i)}, {32'd0, 32'(i)}, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b11, {32'd201, 32'd200}, {32'h21, 32'h20}, 1'b0, 1'b0);
        vectors++;
        if (o_full !== 1'b1 || o_count !== 5'd16 || o_drop_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL overflow_first: got full=%b cnt=%0d drop=%0d, want 1 16 1", o_full, o_count, o_drop_cnt);
        end
        step(1'b0, 1'b1, 2'b11, {32'd211, 32'd210}, {32'h31, 32'h30}, 1'b0, 1'b0);
        vectors++;
        if (o_drop_cnt !== 16'd3 || o_count !== 5'd16) begin
            miscompares++;
            $display("FAIL overflow_second: got drop=%0d cnt=%0d, want 3 16", o_drop_cnt, o_count);
        end
        step(1'b0, 1'b1, 2'b11, {32'd301, 32'd300}, {32'h41, 32'h40}, 1'b1, 1'b0);
        vectors++;
        if (o_count !== 5'd16 || o_full !== 1'b1 || o_drop_cnt !== 16'd4 || o_addr !== 32'd101) begin
            miscompares++;
            $display("FAIL full_with_pop: got cnt=%0d full=%b drop=%0d addr=%0d, want 16 1 4 101", o_count, o_full, o_drop_cnt, o_addr);
        end
        for (int i = 0; i < 16; i++) begin
            idle(1'b1);
            vectors++;
            if (o_valid !== (q.size() != 0) || o_count !== 5'(q.size()) || {o_ch, o_addr, o_data, o_ts} !== last_head) begin
                miscompares++;
                $display("FAIL drain %0d: got v=%b cnt=%0d head=%h, want v=%b cnt=%0d head=%h", i, o_valid, o_count, {o_ch, o_addr, o_data, o_ts}, q.size() != 0, q.size(), last_head);
            end
        end
        vectors++;
        if (o_valid !== 1'b0 || o_ch !== 1'b0 || o_addr !== 32'd300 || o_data !== 32'h40) begin
            miscompares++;
            $display("FAIL tail_entry: got v=%b ch=%0d addr=%0d data=%h, want 0 0 300 40", o_valid, o_ch, o_addr, o_data);
        end
    endtask

    task automatic test_wrap_and_clear;
        logic [31:0] dval;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            dval = $urandom;
            step(1'b0, 1'b1, 2'b01, {32'd0, 32'(i)}, {32'd0, dval}, 1'b1, 1'b0);
            vectors++;
            if (o_valid !== 1'b1 || {o_ch, o_addr, o_data, o_ts} !== last_head || o_drop_cnt !== 16'd0) begin
                miscompares++;
                $display("FAIL wrap %0d: got head=%h drop=%0d, want head=%h drop=0", i, {o_ch, o_addr, o_data, o_ts}, o_drop_cnt, last_head);
            end
        end
        idle(1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 2'b01, '0, {32'd0, 32'(i)}, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b11, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b01, '0, '0, 1'b0, 1'b1);
        vectors++;
        if (o_drop_cnt !== 16'd1 || o_count !== 5'd16) begin
            miscompares++;
            $display("FAIL clear_with_drop: got drop=%0d cnt=%0d, want 1 16", o_drop_cnt, o_count);
        end
        step(1'b0, 1'b0, 2'b11, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (o_drop_cnt !== 16'd1 || o_count !== 5'd16) begin
            miscompares++;
            $display("FAIL disabled_strobes: got drop=%0d cnt=%0d, want 1 16", o_drop_cnt, o_count);
        end
    endtask

    task automatic test_random;
        int rdy_pct;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rdy_pct = (i < 200) ? 30 : 80;
            step(1'b0, ($urandom_range(0, 9) != 0), NCH'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 29) == 0));
            vectors++;
            if (o_valid !== (q.size() != 0) || o_count !== 5'(q.size()) || o_full !== (q.size() == DEPTH) ||
                o_drop_cnt !== 16'(drop_m) || {o_ch, o_addr, o_data, o_ts} !== last_head) begin
                miscompares++;
                $display("FAIL random %0d: got v=%b cnt=%0d full=%b drop=%0d head=%h, want v=%b cnt=%0d drop=%0d head=%h",
                         i, o_valid, o_count, o_full, o_drop_cnt, {o_ch, o_addr, o_data, o_ts},
                         q.size() != 0, q.size(), drop_m, last_head);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 2'b11, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 2'b11, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (o_valid !== 1'b0 || o_count !== 5'd0 || o_drop_cnt !== 16'd0 || o_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b cnt=%0d drop=%0d full=%b, want 0 0 0 0", o_valid, o_count, o_drop_cnt, o_full);
        end
        idle(1'b0);
        step(1'b0, 1'b1, 2'b10, {32'd9, 32'd0}, {32'h99, 32'd0}, 1'b0, 1'b0);
        vectors++;
        if (o_valid !== 1'b1 || o_ts !== 32'd1 || o_ch !== 1'b1 || o_addr !== 32'd9 || o_count !== 5'd1) begin
            miscompares++;
            $display("FAIL post_reset_ts: got v=%b ts=%0d ch=%0d addr=%0d cnt=%0d, want 1 1 1 9 1", o_valid, o_ts, o_ch, o_addr, o_count);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_ch_valid = '0; i_ch_addr = '0; i_ch_data = '0;
        i_ready = 1'b0; i_clr_drop = 1'b0;
        ts_m = 0; drop_m = 0; last_head = '0;
        #2;
        test_reset();
        test_single();
        test_multi_enqueue();
        test_overflow();
        test_wrap_and_clear();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
